// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Width of a counter that must reach TIMEOUT_CYCLES inclusive.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester channel and APB bus bundle for apb_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_write_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0]                 rsp_valid_o;
  logic [DATA_WIDTH-1:0]              rsp_rdata_o;
  logic                               rsp_err_o;
  logic [ADDR_WIDTH-1:0]              paddr_o;
  logic                               psel_o;
  logic                               penable_o;
  logic                               pwrite_o;
  logic [DATA_WIDTH-1:0]              pwdata_o;
  logic [DATA_WIDTH-1:0]              prdata_i;
  logic                               pready_i;
  logic                               pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  prdata_i, pready_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output prdata_i, pready_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_i and wraps.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_i) + off) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin multi-requester APB master: IDLE/SETUP/ACCESS sequencing, wait-state absorb.
// Optional ACCESS-phase timeout abort when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  pclk_i,
  input logic                  prstn_i,
  apb_master_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic                   pwrite_q, pwrite_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_any;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
  logic [TO_W-1:0]        wait_q, wait_d;
`else
  logic                   unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i  (bus.req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // Ready is gated by reset directly so it drops the instant prstn_i falls.
  assign bus.req_ready_o = (prstn_i && state_q == IDLE) ? gnt : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_ARB_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          owner_d   = gnt_idx;
          last_d    = gnt_idx;
          paddr_d   = bus.req_addr_i[gnt_idx];
          pwrite_d  = bus.req_write_i[gnt_idx];
          pwdata_d  = bus.req_write_i[gnt_idx] ? bus.req_wdata_i[gnt_idx] : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
`ifdef APB_ARB_TIMEOUT_EN
          wait_d    = '0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready_i) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : bus.prdata_i;
          rsp_err_d            = bus.pslverr_i;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          state_d              = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // This edge ends the TIMEOUT_CYCLES-th waited cycle: abort with error.
        else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          state_d              = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: drivers push expectations on accept,
// monitors pop and compare on rsp_valid_o and on every APB ACCESS cycle.
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int TO = 8;

  typedef struct {
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
    int            t;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    int            acc;
  } apb_t;

  logic pclk;
  logic prstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] rd_data;
  logic          slv_err;
  int            wait_n;
  rsp_t sb_q[$];
  apb_t apb_q[$];
  int   order_q[$];

  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  apb_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk_i  (pclk),
    .prstn_i (prstn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  assign bus.prdata_i  = rd_data;
  assign bus.pslverr_i = slv_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // APB slave: wait_n ACCESS cycles with pready low, then pready high.
  initial begin : slave
    int scnt;
    scnt = 0;
    bus.pready_i = 1'b0;
    forever begin
      @(negedge pclk);
      if (prstn && bus.psel_o && bus.penable_o) begin
        bus.pready_i = (scnt >= wait_n);
        scnt++;
      end else begin
        scnt = 0;
        bus.pready_i = 1'b0;
      end
    end
  end

  initial begin : mon_rsp
    rsp_t e;
    forever begin
      @(negedge pclk);
      if (prstn && bus.rsp_valid_o != '0) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("rsp_owner", 64'(bus.rsp_valid_o), 64'(1 << e.owner));
          chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e.rdata));
          chk("rsp_err",   64'(bus.rsp_err_o),   64'(e.err));
          chk("rsp_cycle", 64'(cyc),             64'(e.t));
        end
      end
    end
  end

  initial begin : mon_apb
    apb_t p;
    int   setup_n;
    int   acc_n;
    setup_n = 0;
    acc_n   = 0;
    forever begin
      @(negedge pclk);
      if (!prstn || !bus.psel_o) begin
        setup_n = 0;
        acc_n   = 0;
      end else if (apb_q.size() == 0) begin
        chk("apb_unexpected_psel", 64'(bus.psel_o), 64'(0));
      end else begin
        p = apb_q[0];
        if (!bus.penable_o) setup_n++;
        else begin
          acc_n++;
          chk("apb_paddr",  64'(bus.paddr_o),  64'(p.addr));
          chk("apb_pwrite", 64'(bus.pwrite_o), 64'(p.wr));
          chk("apb_pwdata", 64'(bus.pwdata_o), 64'(p.wdata));
          if (acc_n == p.acc) begin
            chk("apb_setup_cycles", 64'(setup_n), 64'(1));
            void'(apb_q.pop_front());
            setup_n = 0;
            acc_n   = 0;
          end
        end
      end
    end
  end

  // Hold valid until ready, then push expectations. acc = expected ACCESS cycles.
  task automatic issue(input int r, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int acc,
                       input logic [DW-1:0] erd, input logic eerr, input bit track);
    rsp_t e;
    apb_t p;
    int   n;
    @(negedge pclk);
    bus.req_valid_i[r] = 1'b1;
    bus.req_write_i[r] = wr;
    bus.req_addr_i[r]  = a;
    bus.req_wdata_i[r] = d;
    #1;
    n = 0;
    while (!bus.req_ready_o[r] && n < 200) begin
      @(negedge pclk);
      #1;
      n++;
    end
    if (!bus.req_ready_o[r]) begin
      checks++;
      errors++;
      $display("FAIL grant_wait r%0d: ready not seen in %0d cycles, required 1", r, n);
    end else begin
      p.addr  = a;
      p.wr    = wr;
      p.wdata = wr ? d : '0;
      p.acc   = acc;
      apb_q.push_back(p);
      if (track) begin
        e.owner = r;
        e.rdata = wr ? '0 : erd;
        e.err   = eerr;
        e.t     = cyc + 2 + acc;
        sb_q.push_back(e);
        order_q.push_back(r);
      end
      @(posedge pclk);
      #1;
    end
    bus.req_valid_i[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || apb_q.size() != 0) && n < 100) begin
      @(negedge pclk);
      n++;
    end
    chk("drain_pending", 64'(sb_q.size() + apb_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin : main
    int exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    prstn = 1'b0;
    bus.req_valid_i = '0;
    bus.req_write_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    rd_data = '0;
    slv_err = 1'b0;
    wait_n  = 0;

    repeat (2) @(negedge pclk);
    bus.req_valid_i = '1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rst_psel",      64'(bus.psel_o),      64'(0));
    chk("rst_penable",   64'(bus.penable_o),   64'(0));
    chk("rst_pwrite",    64'(bus.pwrite_o),    64'(0));
    chk("rst_paddr",     64'(bus.paddr_o),     64'(0));
    chk("rst_pwdata",    64'(bus.pwdata_o),    64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(0));
    chk("rst_rsp_err",   64'(bus.rsp_err_o),   64'(0));
    bus.req_valid_i = '0;
    @(negedge pclk);
    prstn = 1'b1;

    // Zero-wait write from requester 0.
    issue(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 1, '0, 1'b0, 1'b1);
    drain();

    // Read from requester 1 with 4 wait states.
    rd_data = 32'h1234_5678;
    wait_n  = 4;
    issue(1, 1'b0, 32'h0000_0020, '0, 5, 32'h1234_5678, 1'b0, 1'b1);
    drain();
    wait_n  = 0;

    // Both requesters contend continuously: strict alternation starting at 0.
    order_q.delete();
    rd_data = 32'hCAFE_0001;
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(0, 1'b1, AW'(32'h100 + i * 4), DW'(32'h5000_0000 + i), 1, '0, 1'b0, 1'b1);
      end
      begin
        for (int j = 0; j < 4; j++)
          issue(1, 1'b0, AW'(32'h200 + j * 4), '0, 1, 32'hCAFE_0001, 1'b0, 1'b1);
      end
    join
    drain();
    chk("rr_count", 64'(order_q.size()), 64'(8));
    for (int k = 0; k < 8 && k < order_q.size(); k++)
      chk("rr_order", 64'(order_q[k]), 64'(exp_order[k]));

    // Slave error on a read.
    slv_err = 1'b1;
    rd_data = 32'hDEAD_BEEF;
    issue(0, 1'b0, 32'h0000_0030, '0, 1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    drain();
    slv_err = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never ready: abort after TO waited cycles, then a normal transfer.
    wait_n = 1000;
    issue(1, 1'b0, 32'h0000_0050, '0, TO, '0, 1'b1, 1'b1);
    drain();
    wait_n = 0;
    issue(0, 1'b1, 32'h0000_0060, 32'h0BAD_F00D, 1, '0, 1'b0, 1'b1);
    drain();
`endif

    // Reset in the middle of a stalled write ACCESS.
    wait_n = 1000;
    issue(0, 1'b1, 32'h0000_0077, 32'h3C3C_3C3C, 1000, '0, 1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    chk("pre_rst_penable", 64'(bus.penable_o), 64'(1));
    bus.req_valid_i = '1;
    #2;
    prstn = 1'b0;
    #1;
    chk("midrst_psel",      64'(bus.psel_o),      64'(0));
    chk("midrst_penable",   64'(bus.penable_o),   64'(0));
    chk("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    chk("midrst_req_ready", 64'(bus.req_ready_o), 64'(0));
    chk("midrst_paddr",     64'(bus.paddr_o),     64'(0));
    chk("midrst_pwdata",    64'(bus.pwdata_o),    64'(0));
    chk("midrst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(0));
    chk("midrst_rsp_err",   64'(bus.rsp_err_o),   64'(0));
    bus.req_valid_i = '0;
    sb_q.delete();
    apb_q.delete();
    wait_n = 0;
    @(negedge pclk);
    prstn = 1'b1;

    // After release requester 0 wins over a simultaneous requester 1.
    order_q.delete();
    rd_data = 32'h0F0F_0F0F;
    fork
      issue(1, 1'b0, 32'h0000_0084, '0, 1, 32'h0F0F_0F0F, 1'b0, 1'b1);
      issue(0, 1'b1, 32'h0000_0080, 32'h1111_2222, 1, '0, 1'b0, 1'b1);
    join
    drain();
    chk("post_rst_count", 64'(order_q.size()), 64'(2));
    if (order_q.size() == 2) begin
      chk("post_rst_first",  64'(order_q[0]), 64'(0));
      chk("post_rst_second", 64'(order_q[1]), 64'(1));
    end

    repeat (3) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Multi-requester APB master that shares one APB bus among NUM_REQ internal requesters. Each requester issues single transfers over a valid/ready request channel; the block grants round-robin, sequences the APB SETUP/ACCESS phases, absorbs slave wait states and returns read data and error per requester. It sits between bus-side masters (DMA, CSR bridge, test sequencers) and the APB slave fabric.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit (used only with APB_ARB_TIMEOUT_EN)
- pclk_i  in  1  clock
- prstn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester transfer request
- req_write_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready_o  out  NUM_REQ  one-hot accept; request i captured when valid&ready
- rsp_valid_o  out  NUM_REQ  one-cycle completion pulse for requester i
- rsp_rdata_o  out  DATA_WIDTH  read data, valid with rsp_valid_o
- rsp_err_o  out  1  error flag, valid with rsp_valid_o
- paddr_o  out  ADDR_WIDTH  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_WIDTH  APB write data
- prdata_i  in  DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- IDLE: if any req_valid_i, the arbiter asserts req_ready_o for exactly one winner (combinational from state and req_valid_i); addr/write/wdata captured; next state SETUP. No request: stay IDLE.
- Round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updated on accept; resets to NUM_REQ-1 so requester 0 wins first.
- SETUP: psel_o=1, penable_o=0; unconditional move to ACCESS.
- ACCESS: psel_o=1, penable_o=1; stay while pready_i=0; on pready_i=1 register prdata_i (reads; 0 for writes) and pslverr_i, pulse rsp_valid_o[owner], go IDLE.
- paddr_o/pwrite_o/pwdata_o stable from SETUP through ACCESS; hold last values in IDLE. pwdata_o = 0 for reads.
- req_ready_o is 0 outside IDLE and while prstn_i is low.
- Reset (any state, including mid-ACCESS): outputs go immediately to reset values; in-flight transfer dropped, no response.
- Reset values: psel_o, penable_o, pwrite_o, req_ready_o, rsp_valid_o, rsp_err_o = 0; paddr_o, pwdata_o, rsp_rdata_o = 0.

## Timing
- Accept at edge T; SETUP cycle T..T+1 (psel_o high after T); ACCESS from T+1.
- Zero-wait transfer: rsp_valid_o high in the cycle after the completing edge; 3 cycles accept-to-response.
- Each pready_i=0 ACCESS cycle adds one cycle.
- Response cycle is IDLE; a new request may be accepted in the same cycle, so minimum spacing is 3 cycles per transfer.
- Simultaneous requests: one grant per IDLE cycle; the losing request is held by the requester (valid must stay high until ready).

## Configuration
- APB_ARB_TIMEOUT_EN defined: counter of ACCESS cycles with pready_i=0, width $clog2(TIMEOUT_CYCLES+1); when TIMEOUT_CYCLES waited cycles are reached without pready_i, abort: psel_o/penable_o drop next cycle, rsp_valid_o pulses with rsp_err_o=1, rsp_rdata_o=0, FSM to IDLE. Counter clears on entering SETUP.
- Not defined: no counter; ACCESS waits indefinitely.

## Structure
- Package apb_arb_pkg: state enum typedef (IDLE, SETUP, ACCESS) and the timeout counter width function/localparam.
- Sub-module apb_rr_arbiter: request vector + last_grant pointer -> one-hot grant and encoded index; purely combinational, pointer register in the parent.

## Test plan
- Requester 0 write addr 0x0000_0010 data 0xA5A5_A5A5, pready_i tied 1 -> psel high 2 cycles, penable 1 cycle, rsp_valid_o[0] pulses 3 cycles after accept, rsp_err_o=0.
- Requester 1 read addr 0x0000_0020, pready_i low 4 ACCESS cycles, prdata_i 0x1234_5678 -> ACCESS lasts 5 cycles, rsp_rdata_o=0x1234_5678 on rsp_valid_o[1].
- Both requesters valid continuously for 4 transfers each -> grant order 0,1,0,1,...; no starvation; address stable through every ACCESS.
- pslverr_i=1 with pready_i=1 on read -> rsp_err_o=1 with rsp_valid_o.
- APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready_i held 0 -> abort after 8 wait cycles, rsp_err_o=1, rsp_rdata_o=0, next request accepted.
- prstn_i asserted during ACCESS -> psel_o/penable_o/rsp_valid_o 0 immediately; after release requester 0 wins first.
